// File: rtl/org_line_loader.sv
// rtl/org_line_loader.sv - packs 8-pixel stream beats into 32-pixel lines for the original-pixel buffer
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start_i, sel_i  one-cycle load request and plane select (0 luma, 1 chroma), sampled in IDLE
//   in_valid_i, in_data_i, in_ready_o
//                   8-pixel input beat handshake, leftmost pixel in the MSBs
//   stall_i         buffer owned by a read; suppresses the write strobe
//   a_wen_o, a_addr_o, a_wdata_o
//                   buffer line-write port, address {plane, line}
//   busy_o, done_o  load in progress / one-cycle completion pulse

module org_line_loader #(
    parameter int PIXEL_WIDTH    = 8,
    parameter int BEATS_PER_LINE = 4,
    parameter int LINES          = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start_i,
    input  logic                      sel_i,
    input  logic                      in_valid_i,
    input  logic [PIXEL_WIDTH*8-1:0]  in_data_i,
    output logic                      in_ready_o,
    input  logic                      stall_i,
    output logic                      a_wen_o,
    output logic [5:0]                a_addr_o,
    output logic [PIXEL_WIDTH*32-1:0] a_wdata_o,
    output logic                      busy_o,
    output logic                      done_o
);

    localparam int         BEAT_W    = PIXEL_WIDTH * 8;
    localparam int         LINE_W    = PIXEL_WIDTH * 32;
    localparam logic [1:0] LAST_BEAT = 2'(BEATS_PER_LINE - 1);
    localparam logic [5:0] LINES_C   = 6'(LINES);
    localparam logic [5:0] LAST_LINE = 6'(LINES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [1:0]        beat_cnt_q;
    logic [5:0]        in_line_cnt_q;   // lines fully assembled
    logic [5:0]        line_cnt_q;      // lines written to the buffer
    logic              plane_q;
    logic              pend_q;          // output register holds an unwritten line
    logic [BEAT_W-1:0] asm0_q, asm1_q, asm2_q;
    logic [LINE_W-1:0] wdata_q;
    logic [5:0]        addr_q;

    logic accept;
    logic line_done;
    logic wr_fire;

    // The last beat of a line is refused only when it would overwrite a line
    // that is still waiting behind a read; earlier beats go into the assembly
    // slots and cannot disturb the pending write.
    assign in_ready_o = (state_q == S_LOAD) && (in_line_cnt_q < LINES_C) &&
                        !(pend_q && stall_i && (beat_cnt_q == LAST_BEAT));
    assign a_wen_o    = pend_q & ~stall_i;
    assign a_addr_o   = addr_q;
    assign a_wdata_o  = wdata_q;
    assign busy_o     = (state_q == S_LOAD) || (state_q == S_FLUSH);
    assign done_o     = (state_q == S_DONE);

    assign accept    = in_valid_i & in_ready_o;
    assign line_done = accept && (beat_cnt_q == LAST_BEAT);
    assign wr_fire   = a_wen_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                // Leave as soon as the final line is captured; its write is
                // then always issued from FLUSH, so completion is seen there.
                if (line_done && (in_line_cnt_q == LAST_LINE)) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (wr_fire && (line_cnt_q == LAST_LINE)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt_q    <= '0;
            in_line_cnt_q <= '0;
            line_cnt_q    <= '0;
            plane_q       <= 1'b0;
            pend_q        <= 1'b0;
            asm0_q        <= '0;
            asm1_q        <= '0;
            asm2_q        <= '0;
            wdata_q       <= '0;
            addr_q        <= '0;
        end else begin
            if ((state_q == S_IDLE) && start_i) begin
                plane_q       <= sel_i;
                beat_cnt_q    <= '0;
                in_line_cnt_q <= '0;
                line_cnt_q    <= '0;
            end

            if (accept) begin
                case (beat_cnt_q)
                    2'd0:    asm0_q <= in_data_i;
                    2'd1:    asm1_q <= in_data_i;
                    2'd2:    asm2_q <= in_data_i;
                    default: ;
                endcase
                beat_cnt_q <= (beat_cnt_q == LAST_BEAT) ? 2'd0 : beat_cnt_q + 2'd1;
            end

            if (line_done) begin
                wdata_q       <= {asm0_q, asm1_q, asm2_q, in_data_i};
                addr_q        <= {plane_q, in_line_cnt_q[4:0]};
                in_line_cnt_q <= in_line_cnt_q + 6'd1;
            end

            if (wr_fire) begin
                line_cnt_q <= line_cnt_q + 6'd1;
            end

            // A line captured in the same cycle as a write keeps pend set.
            if (line_done) begin
                pend_q <= 1'b1;
            end else if (wr_fire) begin
                pend_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_org_line_loader.sv
// tb/tb_org_line_loader.sv - self-checking bench for org_line_loader

module tb_org_line_loader;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start_i = 1'b0;
    logic         sel_i = 1'b0;
    logic         in_valid_i = 1'b0;
    logic [63:0]  in_data_i = '0;
    logic         in_ready_o;
    logic         stall_i = 1'b0;
    logic         a_wen_o;
    logic [5:0]   a_addr_o;
    logic [255:0] a_wdata_o;
    logic         busy_o;
    logic         done_o;

    org_line_loader #(.PIXEL_WIDTH(8), .BEATS_PER_LINE(4), .LINES(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .sel_i      (sel_i),
        .in_valid_i (in_valid_i),
        .in_data_i  (in_data_i),
        .in_ready_o (in_ready_o),
        .stall_i    (stall_i),
        .a_wen_o    (a_wen_o),
        .a_addr_o   (a_addr_o),
        .a_wdata_o  (a_wdata_o),
        .busy_o     (busy_o),
        .done_o     (done_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: a queue of lines awaiting their write, filled from
    // accepted beats; a write is due whenever a line is queued and no read
    // owns the buffer.
    logic [255:0] q_data[$];
    logic [5:0]   q_addr[$];
    logic [255:0] acc_line = '0;
    int           beat_in_line = 0;
    int           lines_acc = 0;
    int           writes = 0;
    bit           m_busy = 0;
    bit           m_done = 0;
    bit           m_plane = 0;
    bit           exp_wen, exp_ready, last_wr, nb, nd;

    int           wr_count, wr_hi, done_count, hold_cycles, notready_cycles;
    logic [5:0]   first_addr, last_addr;
    logic [255:0] first_data;

    task automatic clear_stats();
        wr_count = 0; wr_hi = 0; done_count = 0; hold_cycles = 0; notready_cycles = 0;
        first_addr = '0; last_addr = '0; first_data = '0;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_ready", in_ready_o, 0);
            chk("rst_wen", a_wen_o, 0);
            chk("rst_addr", a_addr_o, 0);
            chk("rst_wdata", a_wdata_o, 0);
            chk("rst_busy", busy_o, 0);
            chk("rst_done", done_o, 0);
            q_data.delete(); q_addr.delete();
            beat_in_line = 0; lines_acc = 0; writes = 0;
            m_busy = 0; m_done = 0; m_plane = 0;
        end else begin
            exp_wen   = (q_data.size() > 0) && !stall_i;
            exp_ready = m_busy && (lines_acc < 32) &&
                        !((q_data.size() > 0) && stall_i && (beat_in_line == 3));
            chk("wen", a_wen_o, exp_wen);
            chk("ready", in_ready_o, exp_ready);
            chk("busy", busy_o, m_busy);
            chk("done", done_o, m_done);
            if (done_o) done_count++;
            if (q_data.size() > 0) begin
                chk("addr", a_addr_o, q_addr[0]);
                chk("wdata", a_wdata_o, q_data[0]);
                if (!a_wen_o) hold_cycles++;
            end
            last_wr = 0;
            if (a_wen_o) begin
                if (wr_count == 0) begin
                    first_addr = a_addr_o;
                    first_data = a_wdata_o;
                end
                last_addr = a_addr_o;
                wr_count++;
                if (a_addr_o[5]) wr_hi++;
                if (q_data.size() > 0) begin
                    void'(q_data.pop_front());
                    void'(q_addr.pop_front());
                    writes++;
                    if (writes == 32) last_wr = 1;
                end
            end
            if (m_busy && in_valid_i && !in_ready_o && lines_acc < 32) notready_cycles++;
            if (in_valid_i && in_ready_o) begin
                acc_line = {acc_line[191:0], in_data_i};
                beat_in_line++;
                if (beat_in_line == 4) begin
                    q_data.push_back(acc_line);
                    q_addr.push_back({m_plane, 5'(lines_acc)});
                    lines_acc++;
                    beat_in_line = 0;
                end
            end
            nd = last_wr;
            nb = m_busy ? !last_wr : (start_i && !m_done);
            if (!m_busy && !m_done && start_i) begin
                m_plane = sel_i; lines_acc = 0; beat_in_line = 0; writes = 0;
            end
            m_busy = nb;
            m_done = nd;
        end
    end

    function automatic logic [63:0] beat_data(input int k, input int seed);
        logic [63:0] d;
        for (int i = 0; i < 8; i++) d[63-8*i -: 8] = 8'(8*k + i + seed);
        return d;
    endfunction

    task automatic do_start(input bit sel);
        start_i = 1'b1; sel_i = sel;
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    task automatic drive_stream(input int n, input int seed, input bit bubbles,
                                input int stall_at, input int start_at);
        int k = 0;
        int guard = 0;
        int stall_left = 0;
        bit armed = 0;
        bit sdone = 0;
        bit acc;
        while (k < n && guard < 5000) begin
            if (k == stall_at && !armed) begin
                armed = 1; stall_left = 5; stall_i = 1'b1;
            end else if (stall_left > 0) begin
                stall_left--; stall_i = 1'b1;
            end else begin
                stall_i = 1'b0;
            end
            if (k == start_at && !sdone) begin
                start_i = 1'b1; sel_i = 1'b1; sdone = 1;
            end else begin
                start_i = 1'b0;
            end
            in_valid_i = bubbles ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data_i  = beat_data(k, seed);
            @(negedge clk);
            acc = in_valid_i && in_ready_o;
            @(posedge clk); #1;
            if (acc) k++;
            guard++;
        end
        chk("stream_beats", k, n);
        in_valid_i = 1'b0; stall_i = 1'b0; start_i = 1'b0;
    endtask

    task automatic wait_done();
        int guard = 0;
        while (done_count == 0 && guard < 3000) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("done_seen", done_count > 0, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("done_once", done_count, 1);
        chk("busy_after", busy_o, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        clear_stats();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Valid beats with no start are refused.
        in_valid_i = 1'b1; in_data_i = 64'hdead_beef_0123_4567;
        repeat (4) @(posedge clk);
        #1;
        in_valid_i = 1'b0;
        chk("idle_writes", wr_count, 0);

        // Luma, back to back.
        clear_stats();
        do_start(1'b0);
        drive_stream(128, 0, 0, -1, -1);
        wait_done();
        chk("luma_count", wr_count, 32);
        chk("luma_first_addr", first_addr, 6'd0);
        chk("luma_line0", first_data,
            256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
        chk("luma_last_addr", last_addr, 6'd31);
        chk("luma_hold", hold_cycles, 0);
        chk("luma_notready", notready_cycles, 0);

        // Chroma.
        clear_stats();
        do_start(1'b1);
        drive_stream(128, 3, 0, -1, -1);
        wait_done();
        chk("chroma_count", wr_count, 32);
        chk("chroma_hi", wr_hi, 32);
        chk("chroma_first_addr", first_addr, 6'd32);
        chk("chroma_last_addr", last_addr, 6'd63);

        // Five-cycle stall on line 3.
        clear_stats();
        do_start(1'b0);
        drive_stream(128, 5, 0, 15, -1);
        wait_done();
        chk("stall_count", wr_count, 32);
        chk("stall_hold", hold_cycles, 5);
        chk("stall_notready", notready_cycles, 2);

        // Random bubbles.
        clear_stats();
        do_start(1'b1);
        drive_stream(128, 9, 1, -1, -1);
        wait_done();
        chk("bubble_count", wr_count, 32);
        chk("bubble_hi", wr_hi, 32);

        // Start (chroma) while a luma load is running.
        clear_stats();
        do_start(1'b0);
        drive_stream(128, 11, 0, -1, 40);
        wait_done();
        chk("restart_count", wr_count, 32);
        chk("restart_hi", wr_hi, 0);
        chk("restart_last_addr", last_addr, 6'd31);

        // Reset after 2.5 lines.
        clear_stats();
        do_start(1'b0);
        drive_stream(10, 13, 0, -1, -1);
        chk("partial_writes", wr_count, 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ready", in_ready_o, 0);
        chk("arst_wen", a_wen_o, 0);
        chk("arst_addr", a_addr_o, 0);
        chk("arst_wdata", a_wdata_o, 0);
        chk("arst_busy", busy_o, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        clear_stats();
        in_valid_i = 1'b1; in_data_i = 64'h1111_2222_3333_4444;
        repeat (10) @(posedge clk);
        #1;
        in_valid_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("post_reset_writes", wr_count, 0);
        chk("post_reset_busy", busy_o, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/org_line_loader.md
Name: org_line_loader

Overview:
- Upstream feeder for the 64x64x4 line-in/parallel-out original-pixel buffer.
- Accepts a valid/ready stream of 8-pixel beats from the fetch interface and packs 4 beats into one 32-pixel line.
- Issues one buffer write per line on the buffer's line-write port: write enable, 6-bit address, 32-pixel data.
- One start loads 32 lines of one plane: luma at addresses 0..31, chroma at 32..63. A read-priority stall input defers writes while the block reader owns the buffer.

Parameters:
- PIXEL_WIDTH, 8, bits per pixel.
- BEATS_PER_LINE, 4, input beats per 32-pixel line. Fixed; 32/8.
- LINES, 32, lines written per start.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- start_i  input  1  one-cycle pulse. Begins a 32-line load. Sampled only in IDLE.
- sel_i  input  1  plane select, sampled with start_i. 0 = luma, 1 = chroma. Drives a_addr_o[5].
- in_valid_i  input  1  input beat valid.
- in_data_i  input  PIXEL_WIDTH*8  8 pixels. Leftmost pixel in the MSBs.
- in_ready_o  output  1  beat accepted when in_valid_i & in_ready_o.
- stall_i  input  1  buffer busy with a read. Suppresses a_wen_o.
- a_wen_o  output  1  buffer write enable.
- a_addr_o  output  6  {plane, line[4:0]}.
- a_wdata_o  output  PIXEL_WIDTH*32  32 pixels. Leftmost pixel in the MSBs.
- busy_o  output  1  high from the cycle after start until done.
- done_o  output  1  one-cycle pulse after the last line write.

Behaviour:
- Reset values (asynchronous): state IDLE; beat_cnt, line_cnt, plane, pend all 0; assembly and output registers 0.
- Reset output values: in_ready_o=0, a_wen_o=0, a_addr_o=0, a_wdata_o=0, busy_o=0, done_o=0.
- States: IDLE, LOAD, FLUSH, DONE.
- IDLE: start_i=1 latches plane<=sel_i, clears beat_cnt and line_cnt, goes to LOAD. start_i in any other state is ignored.
- LOAD, beat assembly: each accepted beat is written into assembly slot beat_cnt; slot 0 holds bits [32P-1:24P]; beat_cnt increments.
- LOAD, line completion: on acceptance with beat_cnt==3:
  - the full line (assembly plus current beat) moves to the output register;
  - pend<=1, beat_cnt<=0;
  - the address for this line is latched as {plane, in_line_cnt}, and in_line_cnt increments.
- a_wen_o = pend & ~stall_i (combinational from registers). a_addr_o and a_wdata_o come from the output register and hold while pend=1.
- Write completes in any cycle with a_wen_o=1: pend<=0, line_cnt increments. If a new line completes in the same cycle, pend stays 1 with the new data.
- Latency: 4th beat accepted in cycle N gives a_wen_o=1 in cycle N+1 when stall_i=0. Each stalled cycle adds one.
- in_ready_o = (state==LOAD) & (in_line_cnt<LINES) & ~(pend & stall_i & beat_cnt==3). The 4th beat of the next line is held off only while the previous write is still blocked.
- Sustained rate: 1 beat/cycle with no stall.
- LOAD -> FLUSH: after the 32nd line has been accepted (in_line_cnt==LINES).
- FLUSH -> DONE: when the final pending write completes (a_wen_o=1 with line_cnt==31).
- DONE: done_o=1 for exactly one cycle, then IDLE.
- busy_o=1 in LOAD and FLUSH.
- Boundaries:
  - Line index wraps 31 -> end of load; it never writes past address {plane,31}.
  - stall_i held indefinitely: block holds its data, no loss, no duplicate write.
  - in_valid_i without a start: ignored; in_ready_o=0.
  - Asynchronous reset mid-load: partial line and pending write are discarded; no write is issued after reset release.
- The buffer gives writes priority. Upstream arbitration must therefore drive stall_i whenever a buffer read is issued, so a_wen_o never coincides with a read.

Test Plan:
- Luma load, no stall: start_i with sel_i=0, then 128 back-to-back beats where beat k carries pixels 8k..8k+7.
  - 32 writes, addresses 0..31, each one cycle after its 4th beat.
  - Line 0 data = pixels 0..31 with pixel 0 in the MSBs.
  - done_o one cycle after the last write; busy_o low afterwards.
- Chroma load: sel_i=1. a_addr_o runs 32..63; a_addr_o[5]=1 on every write.
- Stall: assert stall_i for 5 cycles while line 3 is pending.
  - a_wen_o=0 for 5 cycles; address 3 and its data stay stable.
  - in_ready_o drops at beat_cnt==3 of line 4.
  - One write per line; none lost or duplicated.
- Bubbles: in_valid_i toggles randomly. Line contents match the reference packing; write count is 32.
- Start while busy: pulse start_i with sel_i=1 mid-load. Plane and counters are unchanged; the load finishes on its original plane.
- Reset mid-load: drop rst_n after 2.5 lines. All outputs go to 0 immediately; no a_wen_o after release until a new start.
